// File: rtl/mod_74x165_ser_tx_pkg.sv
// Shared definitions for the 74x165-style serial transmitter: FSM state
// encodings and the word-width legality helpers.
package mod_74x165_ser_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    localparam int unsigned SLICE_W = 8;

    function automatic bit width_ok(input int unsigned w);
        return (w >= SLICE_W) && ((w % SLICE_W) == 0);
    endfunction

    function automatic bit div_ok(input int unsigned d);
        return d >= 1;
    endfunction

endpackage

// File: rtl/mod_74x165_ser_tx_shreg.sv
// One 8-bit 74x165 slice: synchronous parallel load, shift-left with serial
// input, and only the MSB (Q7) visible, as on the real part.
module mod_74x165_ser_tx_shreg
    import mod_74x165_ser_tx_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               shift,
    input  logic               sin,
    input  logic [SLICE_W-1:0] d,
    output logic               msb
);

    logic [SLICE_W-1:0] q;

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (shift) begin
            q <= {q[SLICE_W-2:0], sin};
        end
    end

    assign msb = q[SLICE_W-1];

endmodule

// File: rtl/mod_74x165_ser_tx.sv
// Serial transmitter for a 74x164/74x595 receiver chain: sends a parallel
// word MSB-first with a per-bit SHIFT_EN strobe and a closing LATCH strobe.
module mod_74x165_ser_tx
    import mod_74x165_ser_tx_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned BIT_DIV = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] D,
    input  logic             VALID,
    output logic             READY,
    output logic             BUSY,
    output logic             SOUT,
    output logic             SHIFT_EN,
    output logic             LATCH
);

    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("WIDTH must be a multiple of 8 and at least 8");
    end
    if (!div_ok(BIT_DIV)) begin : g_bad_div
        $error("BIT_DIV must be at least 1");
    end

    localparam int unsigned NSL = WIDTH / SLICE_W;
    localparam int unsigned BCW = $clog2(WIDTH);
    localparam int unsigned DCW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);
    localparam logic [DCW-1:0] DIV_LAST = DCW'(BIT_DIV - 1);

    state_t         state, state_nxt;
    logic [BCW-1:0] bit_cnt;
    logic [DCW-1:0] div_cnt;
    logic           load, shift;
    logic [NSL:0]   chain;

    // Slice k shifts its MSB into slice k+1; slice 0 takes zeros.
    assign chain[0] = 1'b0;
    for (genvar k = 0; k < NSL; k++) begin : g_slice
        mod_74x165_ser_tx_shreg u_slice (
            .clk   (CLK),
            .rst   (RST),
            .load  (load),
            .shift (shift),
            .sin   (chain[k]),
            .d     (D[k*SLICE_W +: SLICE_W]),
            .msb   (chain[k+1])
        );
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            bit_cnt <= '0;
            div_cnt <= '0;
        end else if (load) begin
            bit_cnt <= BIT_LAST;
            div_cnt <= DIV_LAST;
        end else if (state == ST_SHIFT) begin
            if (div_cnt != '0) begin
                div_cnt <= div_cnt - 1'b1;
            end else if (bit_cnt != '0) begin
                bit_cnt <= bit_cnt - 1'b1;
                div_cnt <= DIV_LAST;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (VALID) begin
                    load      = 1'b1;
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (div_cnt == '0) begin
                    if (bit_cnt != '0) begin
                        shift = 1'b1;
                    end else begin
                        state_nxt = ST_LATCH;
                    end
                end
            end
            ST_LATCH: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Moore outputs, decoded purely from registered state.
    always_comb begin
        READY    = (state == ST_IDLE);
        BUSY     = (state != ST_IDLE);
        SOUT     = (state == ST_SHIFT) && chain[NSL];
        SHIFT_EN = (state == ST_SHIFT) && (div_cnt == '0);
        LATCH    = (state == ST_LATCH);
    end

endmodule

// File: tb/tb_mod_74x165_ser_tx.sv
// Directed plus randomized checks of two transmitter configurations
// (8-bit/div 1 and 16-bit/div 3) against a cycle-indexed frame model.
module tb_mod_74x165_ser_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  d8 = '0;
    logic        valid8 = 1'b0;
    logic        ready8, busy8, sout8, se8, latch8;
    logic [15:0] d16 = '0;
    logic        valid16 = 1'b0;
    logic        ready16, busy16, sout16, se16, latch16;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mod_74x165_ser_tx #(.WIDTH(8), .BIT_DIV(1)) dut8 (
        .CLK(clk), .RST(rst), .D(d8), .VALID(valid8),
        .READY(ready8), .BUSY(busy8), .SOUT(sout8),
        .SHIFT_EN(se8), .LATCH(latch8)
    );

    mod_74x165_ser_tx #(.WIDTH(16), .BIT_DIV(3)) dut16 (
        .CLK(clk), .RST(rst), .D(d16), .VALID(valid16),
        .READY(ready16), .BUSY(busy16), .SOUT(sout16),
        .SHIFT_EN(se16), .LATCH(latch16)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit wide, input logic [15:0] dv, input logic v);
        if (wide) begin
            d16 = dv;
            valid16 = v;
        end else begin
            d8 = dv[7:0];
            valid8 = v;
        end
    endtask

    // {sout, shift_en, latch, ready, busy}
    function automatic logic [4:0] outs(input bit wide);
        if (wide) return {sout16, se16, latch16, ready16, busy16};
        return {sout8, se8, latch8, ready8, busy8};
    endfunction

    task automatic check_outs(input bit wide, input int c, input logic [4:0] exp);
        logic [4:0] o;
        o = outs(wide);
        check($sformatf("sout w%0d c%0d", wide, c), 32'(o[4]), 32'(exp[4]));
        check($sformatf("shift_en w%0d c%0d", wide, c), 32'(o[3]), 32'(exp[3]));
        check($sformatf("latch w%0d c%0d", wide, c), 32'(o[2]), 32'(exp[2]));
        check($sformatf("ready w%0d c%0d", wide, c), 32'(o[1]), 32'(exp[1]));
        check($sformatf("busy w%0d c%0d", wide, c), 32'(o[0]), 32'(exp[0]));
    endtask

    // Caller has VALID=1 with the word on D for the coming edge (edge 0).
    // Checks cycles 1..W*B+2; returns in the IDLE cycle W*B+2.
    task automatic frame(input bit wide, input logic [15:0] w,
                         input int spoil_cycle, input logic [15:0] spoil_d,
                         input bit hold);
        int W, B, n_se, n_latch;
        logic [4:0] exp, o;
        W = wide ? 16 : 8;
        B = wide ? 3 : 1;
        n_se = 0;
        n_latch = 0;
        tick();
        for (int c = 1; c <= W * B + 2; c++) begin
            if (c <= W * B)
                exp = {w[W - 1 - (c - 1) / B], (c % B) == 0, 1'b0, 1'b0, 1'b1};
            else if (c == W * B + 1)
                exp = 5'b00101;
            else
                exp = 5'b00010;
            check_outs(wide, c, exp);
            o = outs(wide);
            n_se += int'(o[3]);
            n_latch += int'(o[2]);
            if (c == W * B + 2) break;
            if (c == spoil_cycle) drive(wide, spoil_d, 1'b1);
            else drive(wide, w, hold);
            tick();
        end
        check($sformatf("shift_en count w%0d", wide), 32'(n_se), 32'(W));
        check($sformatf("latch count w%0d", wide), 32'(n_latch), 32'd1);
    endtask

    initial begin
        bit wide;
        logic [15:0] w, sd;
        int sc, lat;

        // Reset held for two cycles
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_outs(1'b0, 0, 5'b00010);
        check_outs(1'b1, 0, 5'b00010);
        tick();
        check_outs(1'b0, 0, 5'b00010);

        // 8'hA5, single-cycle VALID
        drive(1'b0, 16'h00A5, 1'b1);
        frame(1'b0, 16'h00A5, 0, 16'h0, 1'b0);

        // 16'h8001 at BIT_DIV=3
        drive(1'b1, 16'h8001, 1'b1);
        frame(1'b1, 16'h8001, 0, 16'h0, 1'b0);

        // VALID during busy must be ignored
        drive(1'b0, 16'h003C, 1'b1);
        frame(1'b0, 16'h003C, 4, 16'h00FF, 1'b0);

        // VALID held: back-to-back frames with one IDLE cycle between
        drive(1'b0, 16'h0001, 1'b1);
        frame(1'b0, 16'h0001, 0, 16'h0, 1'b1);
        drive(1'b0, 16'h0080, 1'b1);
        frame(1'b0, 16'h0080, 0, 16'h0, 1'b0);

        // Abort: reset during cycle 4 of an 8'hFF transfer
        drive(1'b0, 16'h00FF, 1'b1);
        tick();
        drive(1'b0, 16'h00FF, 1'b0);
        tick();
        tick();
        tick();
        check_outs(1'b0, 4, 5'b11001);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_outs(1'b0, 5, 5'b00010);
        lat = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            lat += int'(latch8);
            check($sformatf("ready after abort %0d", i), 32'(ready8), 32'd1);
        end
        check("latch after abort", 32'(lat), 32'd0);

        // Randomized words, optionally with an ignored mid-frame request
        for (int n = 0; n < 10; n++) begin
            wide = 1'($urandom_range(0, 1));
            w = 16'($urandom);
            if (!wide) w[15:8] = '0;
            sd = 16'($urandom);
            if (!wide) sd[15:8] = '0;
            sc = int'($urandom_range(0, wide ? 49 : 9));
            drive(wide, w, 1'b1);
            frame(wide, w, sc, sd, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
